// File: rtl/qei_pkg.sv
// qei_pkg: shared types and constants for the quadrature encoder front-end.
// Holds the x4 step classification and the forward AB phase sequence.
`timescale 1ns/1ps
package qei_pkg;

  localparam int ERR_CNT_W = 8;

  // Result of comparing the previous and current filtered AB pair.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Forward rotation visits these {A,B} levels in order, then wraps.
  localparam logic [1:0] AB_SEQ0 = 2'b00;
  localparam logic [1:0] AB_SEQ1 = 2'b10;
  localparam logic [1:0] AB_SEQ2 = 2'b11;
  localparam logic [1:0] AB_SEQ3 = 2'b01;

  // Position of an {A,B} level within the forward sequence.
  function automatic logic [1:0] ab_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      AB_SEQ0: ph = 2'd0;
      AB_SEQ1: ph = 2'd1;
      AB_SEQ2: ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  // A phase advance of +1 is forward, -1 reverse, 2 means both pins moved.
  function automatic step_t classify_step(input logic [1:0] prev_ab,
                                          input logic [1:0] cur_ab);
    logic [1:0] delta;
    step_t      st;
    delta = ab_phase(cur_ab) - ab_phase(prev_ab);
    case (delta)
      2'd0:    st = STEP_NONE;
      2'd1:    st = STEP_FWD;
      2'd3:    st = STEP_REV;
      default: st = STEP_ERR;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/qei_input_filter.sv
// qei_input_filter: two-flop synchroniser followed by a stability filter.
// A new level is accepted only after FILT_LEN consecutive clocks of
// disagreement with the current filtered value; FILT_LEN=0 bypasses it.
`timescale 1ns/1ps
module qei_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  logic meta_q;
  logic sync_q;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign filt_o = sync_q;
    end else begin : g_filter
      localparam int CNT_W = $clog2(FILT_LEN + 1);
      // Counter value on the clock that completes the stable run.
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             filt_q, filt_d;

      // Count disagreeing samples; accept the sample once the run is long enough.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Filter state registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt_o = filt_q;
    end
  endgenerate

endmodule

// File: rtl/qei_decoder.sv
// qei_decoder: conditions raw A/B/Z encoder pins and decodes x4 quadrature
// into a wrapping signed position with index capture and error counting.
// Optional velocity sampling is built when QEI_VELOCITY_EN is defined.
`timescale 1ns/1ps
module qei_decoder
  import qei_pkg::*;
#(
  parameter int POS_W     = 32,
  parameter int FILT_LEN  = 4,
  parameter int IDX_RESET = 0,
  parameter int VEL_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_z,
  input  logic                    pos_clr,
  input  logic                    pos_load,
  input  logic [POS_W-1:0]        pos_load_val,
  input  logic                    index_arm,
  input  logic                    index_ack,
  input  logic                    vel_strobe,
  output logic [POS_W-1:0]        position,
  output logic [POS_W-1:0]        index_pos,
  output logic                    index_flag,
  output logic                    dir,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid
);

  // Bit order of the pin vectors: 0 = A, 1 = B, 2 = Z.
  logic [2:0] raw_vec;
  logic [2:0] filt_vec;

  assign raw_vec = {enc_z, enc_b, enc_a};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
      qei_input_filter #(
        .FILT_LEN(FILT_LEN)
      ) u_filt (
        .clk   (clk),
        .reset (reset),
        .raw_i (raw_vec[gi]),
        .filt_o(filt_vec[gi])
      );
    end
  endgenerate

  logic [1:0]           ab_cur;
  logic [1:0]           ab_prev_q;
  logic                 z_prev_q;
  step_t                step;
  logic                 capture;

  logic [POS_W-1:0]     pos_q, pos_d;
  logic [POS_W-1:0]     idx_pos_q, idx_pos_d;
  logic                 flag_q, flag_d;
  logic                 dir_q, dir_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  assign ab_cur  = {filt_vec[0], filt_vec[1]};
  assign step    = classify_step(ab_prev_q, ab_cur);
  assign capture = filt_vec[2] & ~z_prev_q & index_arm;

  // Next position, direction, error count and index capture.
  always_comb begin
    pos_d     = pos_q;
    dir_d     = dir_q;
    err_d     = err_q;
    idx_pos_d = idx_pos_q;
    flag_d    = flag_q;

    // Higher-priority actions swallow a coincident step.
    if (pos_clr) begin
      pos_d = '0;
    end else if (pos_load) begin
      pos_d = pos_load_val;
    end else if ((IDX_RESET != 0) && capture) begin
      pos_d = '0;
    end else if (step == STEP_FWD) begin
      pos_d = pos_q + POS_W'(1);
    end else if (step == STEP_REV) begin
      pos_d = pos_q - POS_W'(1);
    end

    if (step == STEP_FWD) begin
      dir_d = 1'b1;
    end else if (step == STEP_REV) begin
      dir_d = 1'b0;
    end

    if ((step == STEP_ERR) && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end

    // Capture sees the position before this cycle's update and beats an ack.
    if (capture) begin
      idx_pos_d = pos_q;
      flag_d    = 1'b1;
    end else if (index_ack) begin
      flag_d = 1'b0;
    end
  end

  // Decoder state registers; previous AB always follows the filtered pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_prev_q <= '0;
      z_prev_q  <= 1'b0;
      pos_q     <= '0;
      idx_pos_q <= '0;
      flag_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      ab_prev_q <= ab_cur;
      z_prev_q  <= filt_vec[2];
      pos_q     <= pos_d;
      idx_pos_q <= idx_pos_d;
      flag_q    <= flag_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign position   = pos_q;
  assign index_pos  = idx_pos_q;
  assign index_flag = flag_q;
  assign dir        = dir_q;
  assign err_cnt    = err_q;

`ifdef QEI_VELOCITY_EN
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = -VEL_MAX;
  localparam logic signed [VEL_W-1:0] VEL_ONE = {{(VEL_W-1){1'b0}}, 1'b1};

  logic signed [VEL_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    vv_q, vv_d;

  // Saturating step accumulator, sampled and restarted on each strobe.
  always_comb begin
    acc_sum = acc_q;
    if ((step == STEP_FWD) && (acc_q != VEL_MAX)) begin
      acc_sum = acc_q + VEL_ONE;
    end else if ((step == STEP_REV) && (acc_q != VEL_MIN)) begin
      acc_sum = acc_q - VEL_ONE;
    end
    acc_d = acc_sum;
    vel_d = vel_q;
    vv_d  = 1'b0;
    if (vel_strobe) begin
      vel_d = acc_sum;
      acc_d = '0;
      vv_d  = 1'b1;
    end
  end

  // Velocity state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      vel_q <= '0;
      vv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vel_q <= vel_d;
      vv_q  <= vv_d;
    end
  end

  assign velocity  = vel_q;
  assign vel_valid = vv_q;
`else
  logic unused_vel_strobe;
  assign unused_vel_strobe = vel_strobe;
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qei_decoder.sv
// tb_qei_decoder: randomized and directed checks of qei_decoder against a
// transaction-level model that tracks the accepted AB/Z levels.
`timescale 1ns/1ps
module tb_qei_decoder;

  localparam int POS_W    = 32;
  localparam int FILT_LEN = 4;
  localparam int VEL_W    = 16;
`ifdef QEI_VELOCITY_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0;
  logic pos_clr = 1'b0, pos_load = 1'b0;
  logic [POS_W-1:0] pos_load_val = '0;
  logic index_arm = 1'b0, index_ack = 1'b0, vel_strobe = 1'b0;

  logic [POS_W-1:0] pos0, idx0, pos1, idx1;
  logic flag0, dir0, vv0, flag1, dir1, vv1;
  logic [7:0] err0, err1;
  logic signed [VEL_W-1:0] vel0, vel1;

  qei_decoder #(.POS_W(POS_W), .FILT_LEN(FILT_LEN), .IDX_RESET(0), .VEL_W(VEL_W)) dut0 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .pos_clr(pos_clr), .pos_load(pos_load), .pos_load_val(pos_load_val),
    .index_arm(index_arm), .index_ack(index_ack), .vel_strobe(vel_strobe),
    .position(pos0), .index_pos(idx0), .index_flag(flag0), .dir(dir0),
    .err_cnt(err0), .velocity(vel0), .vel_valid(vv0));

  qei_decoder #(.POS_W(POS_W), .FILT_LEN(FILT_LEN), .IDX_RESET(1), .VEL_W(VEL_W)) dut1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .pos_clr(pos_clr), .pos_load(pos_load), .pos_load_val(pos_load_val),
    .index_arm(index_arm), .index_ack(index_ack), .vel_strobe(vel_strobe),
    .position(pos1), .index_pos(idx1), .index_flag(flag1), .dir(dir1),
    .err_cnt(err1), .velocity(vel1), .vel_valid(vv1));

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Quadrature phase of each {A,B} level, and the level for each phase.
  int         phase_of [4] = '{0, 3, 1, 2};
  logic [1:0] level_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Reference model state.
  logic [POS_W-1:0] m_pos0, m_pos1, m_idx0, m_idx1;
  logic m_flag, m_dir, m_z;
  int   m_err, m_ph, m_vel;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos0 = '0; m_pos1 = '0; m_idx0 = '0; m_idx1 = '0;
    m_flag = 1'b0; m_dir = 1'b0; m_z = 1'b0;
    m_err = 0; m_ph = 0; m_vel = 0;
  endtask

  // Apply one accepted level change to the model.
  task automatic model_step(input logic [1:0] ab, input logic z, input logic arm, input logic ack);
    int ph_new, delta, st;
    ph_new = phase_of[ab];
    delta  = (ph_new - m_ph + 4) % 4;
    st     = (delta == 1) ? 1 : ((delta == 3) ? -1 : 0);
    if (ack) m_flag = 1'b0;
    if (z && !m_z && arm) begin
      m_idx0 = m_pos0;
      m_idx1 = m_pos1;
      m_flag = 1'b1;
      m_pos1 = '0;
    end else begin
      m_pos1 = m_pos1 + POS_W'(st);
    end
    m_pos0 = m_pos0 + POS_W'(st);
    if (delta == 2 && m_err < 255) m_err++;
    if (st == 1) m_dir = 1'b1;
    if (st == -1) m_dir = 1'b0;
    m_vel += st;
    m_ph = ph_new;
    m_z  = z;
  endtask

  // Drive new levels, hold them, then update the model.
  task automatic apply(input logic [1:0] ab, input logic z, input logic arm,
                       input logic ack, input int hold);
    {enc_a, enc_b} = ab;
    enc_z = z; index_arm = arm; index_ack = ack;
    @(posedge clk) #1;
    index_ack = 1'b0;
    repeat (hold - 1) @(posedge clk) #1;
    model_step(ab, z, arm, ack);
  endtask

  task automatic pulse_ctl(input logic clr, input logic load, input logic [POS_W-1:0] val);
    pos_clr = clr; pos_load = load; pos_load_val = val;
    @(posedge clk) #1;
    pos_clr = 1'b0; pos_load = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pos"},  pos0, m_pos0);
    check_val({tag, ".pos1"}, pos1, m_pos1);
    check_val({tag, ".dir"},  32'(dir0), 32'(m_dir));
    check_val({tag, ".err"},  32'(err0), 32'(m_err));
    check_val({tag, ".flag"}, 32'(flag0), 32'(m_flag));
    check_val({tag, ".idx"},  idx0, m_idx0);
    check_val({tag, ".idx1"}, idx1, m_idx1);
  endtask

  task automatic strobe_check(input string tag);
    logic [VEL_W-1:0] exp_v;
    exp_v = VEL_EN ? VEL_W'(m_vel) : '0;
    vel_strobe = 1'b1;
    @(posedge clk) #1;
    vel_strobe = 1'b0;
    check_val({tag, ".vel"},   32'(vel0), 32'(exp_v));
    check_val({tag, ".valid"}, 32'(vv0), 32'(VEL_EN));
    @(posedge clk) #1;
    check_val({tag, ".valid_drop"}, 32'(vv0), 32'(0));
    m_vel = 0;
  endtask

  initial begin : main
    logic [1:0] nxt;
    logic [POS_W-1:0] hold_pos;
    model_reset();

    // Reset state while reset is held.
    repeat (3) @(posedge clk) #1;
    check_all("reset");
    check_val("reset.vel", 32'(vel0), 32'(0));
    check_val("reset.valid", 32'(vv0), 32'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;

    // Forward sweep: first step latency, then 100 steps total.
    enc_a = 1'b1;
    repeat (6) @(posedge clk) #1;
    check_val("latency.before", pos0, 32'd0);
    @(posedge clk) #1;
    check_val("latency.at7", pos0, 32'd1);
    @(posedge clk) #1;
    model_step(2'b10, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 100; i++) apply(level_of[(i + 1) % 4], 1'b0, 1'b0, 1'b0, 8);
    check_all("sweep");
    check_val("sweep.pos100", pos0, 32'd100);
    $display("txn sweep: pos=%0d dir=%0d err=%0d", pos0, dir0, err0);

    // Reverse from zero, then signed wrap via load.
    pulse_ctl(1'b1, 1'b0, '0);
    m_pos0 = '0; m_pos1 = '0;
    for (int i = 0; i < 3; i++) apply(level_of[(m_ph + 3) % 4], 1'b0, 1'b0, 1'b0, 8);
    check_all("reverse");
    check_val("reverse.wrap", pos0, 32'hFFFF_FFFD);
    pulse_ctl(1'b0, 1'b1, 32'h7FFF_FFFF);
    m_pos0 = 32'h7FFF_FFFF; m_pos1 = 32'h7FFF_FFFF;
    apply(level_of[(m_ph + 1) % 4], 1'b0, 1'b0, 1'b0, 8);
    check_val("wrap.max", pos0, 32'h8000_0000);
    $display("txn wrap: pos=0x%0h", pos0);

    // Glitch rejection: 3-clock pulse on A.
    enc_a = ~enc_a;
    repeat (3) @(posedge clk) #1;
    enc_a = ~enc_a;
    repeat (8) @(posedge clk) #1;
    check_all("glitch");
    // Illegal 00 -> 11.
    apply(2'b01, 1'b0, 1'b0, 1'b0, 8);
    apply(2'b00, 1'b0, 1'b0, 1'b0, 8);
    hold_pos = m_pos0;
    apply(2'b11, 1'b0, 1'b0, 1'b0, 8);
    check_all("illegal");
    check_val("illegal.pos_same", pos0, hold_pos);
    $display("txn illegal: err=%0d", err0);

    // Index capture, ack, and ack coincident with a second capture.
    pulse_ctl(1'b0, 1'b1, 32'd42);
    m_pos0 = 32'd42; m_pos1 = 32'd42;
    apply(2'b11, 1'b1, 1'b1, 1'b0, 10);
    check_all("index1");
    check_val("index1.pos42", idx0, 32'd42);
    apply(2'b11, 1'b1, 1'b1, 1'b1, 8);
    check_all("index.ack");
    apply(2'b11, 1'b0, 1'b1, 1'b0, 8);
    pulse_ctl(1'b0, 1'b1, 32'd50);
    m_pos0 = 32'd50; m_pos1 = 32'd50;
    enc_z = 1'b1;
    repeat (6) @(posedge clk) #1;
    index_ack = 1'b1;
    @(posedge clk) #1;
    index_ack = 1'b0;
    repeat (2) @(posedge clk) #1;
    model_step(2'b11, 1'b1, 1'b1, 1'b0);
    check_all("index2");
    check_val("index2.flag_kept", 32'(flag0), 32'(1));
    $display("txn index: idx=%0d flag=%0d pos_idxreset=%0d", idx0, flag0, pos1);
    apply(2'b11, 1'b0, 1'b0, 1'b1, 8);

    // Priority: clear+load coinciding with a forward step.
    nxt = level_of[(m_ph + 1) % 4];
    {enc_a, enc_b} = nxt;
    repeat (6) @(posedge clk) #1;
    pulse_ctl(1'b1, 1'b1, 32'h1234_5678);
    @(posedge clk) #1;
    model_step(nxt, m_z, 1'b0, 1'b0);
    m_pos0 = '0; m_pos1 = '0;
    check_all("prio.clr");
    // Load alone coinciding with a reverse step.
    nxt = level_of[(m_ph + 3) % 4];
    {enc_a, enc_b} = nxt;
    repeat (6) @(posedge clk) #1;
    pulse_ctl(1'b0, 1'b1, 32'h1234_5678);
    @(posedge clk) #1;
    model_step(nxt, m_z, 1'b0, 1'b0);
    m_pos0 = 32'h1234_5678; m_pos1 = 32'h1234_5678;
    check_all("prio.load");

    // Asynchronous reset mid-sweep.
    {enc_a, enc_b} = level_of[(m_ph + 1) % 4];
    repeat (3) @(posedge clk) #1;
    #5 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_val("async_rst.vel", 32'(vel0), 32'(0));
    {enc_a, enc_b} = 2'b00; enc_z = 1'b0; index_arm = 1'b0;
    repeat (3) @(posedge clk) #1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;

    // Velocity: +10 then -3.
    for (int i = 0; i < 10; i++) apply(level_of[(m_ph + 1) % 4], 1'b0, 1'b0, 1'b0, 8);
    strobe_check("vel.fwd10");
    for (int i = 0; i < 3; i++) apply(level_of[(m_ph + 3) % 4], 1'b0, 1'b0, 1'b0, 8);
    strobe_check("vel.rev3");
    check_all("vel");

    // Randomized walk: any AB level, random Z/arm/ack, glitches, loads.
    for (int t = 0; t < 60; t++) begin
      logic [1:0] ab;
      if ($urandom_range(0, 3) == 0) begin
        enc_b = ~enc_b;
        repeat ($urandom_range(1, 3)) @(posedge clk) #1;
        enc_b = ~enc_b;
        repeat (4) @(posedge clk) #1;
      end
      if ($urandom_range(0, 9) == 0) begin
        pos_load_val = $urandom;
        pulse_ctl(1'b0, 1'b1, pos_load_val);
        m_pos0 = pos_load_val; m_pos1 = pos_load_val;
      end
      ab = 2'($urandom_range(0, 3));
      apply(ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), $urandom_range(8, 12));
      check_all("rand");
      $display("txn %0d: ab=%b z=%b arm=%b pos=0x%0h err=%0d flag=%0d",
               t, ab, enc_z, index_arm, pos0, err0, flag0);
    end
    strobe_check("vel.rand");

    // Error counter saturation.
    hold_pos = m_pos0;
    for (int i = 0; i < 260; i++) apply({enc_a, enc_b} ^ 2'b11, enc_z, 1'b0, 1'b0, 8);
    check_all("err_sat");
    check_val("err_sat.255", 32'(err0), 32'd255);
    check_val("err_sat.pos", pos0, hold_pos);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qei_decoder.md
Name: qei_decoder

Overview:
- Quadrature encoder front-end for one motor channel.
- Takes the raw encoder A, B and Z pins (one M*_ENC_* group) and conditions them with synchronisers and a digital glitch filter.
- Decodes x4 quadrature into a signed wrapping position count, with index capture, illegal-transition counting and optional velocity sampling.
- Sits directly upstream of the QEI register interface inside the system, which reads its outputs.

Parameters:
- POS_W, 32, width of the position counter and index capture registers.
- FILT_LEN, 4, consecutive stable clocks needed to accept a new input level; 0 bypasses the filter.
- IDX_RESET, 0, when 1 an armed index edge also clears the position.
- VEL_W, 16, width of the signed velocity output.

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- enc_a  in  1  raw encoder A pin, asynchronous.
- enc_b  in  1  raw encoder B pin, asynchronous.
- enc_z  in  1  raw encoder index pin, asynchronous.
- pos_clr  in  1  synchronous clear of position.
- pos_load  in  1  synchronous load of position from pos_load_val.
- pos_load_val  in  POS_W  position load value.
- index_arm  in  1  enables index capture (level).
- index_ack  in  1  clears index_flag.
- vel_strobe  in  1  velocity sample pulse.
- position  out  POS_W  current count, two's complement.
- index_pos  out  POS_W  position captured at last armed index edge.
- index_flag  out  1  sticky: an index capture occurred.
- dir  out  1  direction of last valid step; 1 = forward.
- err_cnt  out  8  illegal-transition count, saturating.
- velocity  out  VEL_W  signed step count over the last strobe interval.
- vel_valid  out  1  one-cycle pulse when velocity is updated.

Behaviour:
- Reset (async, active-high): all registers go to 0, including synchronisers, filters, the previous-AB state, all outputs, and both velocity outputs.
- Synchronisers: 2-flop synchroniser on each of A, B and Z.
- Filter, per signal:
  - A counter increments while the synchronised sample differs from the filtered value; it clears when they match.
  - When the counter reaches FILT_LEN, the filtered value takes the sample and the counter clears.
  - FILT_LEN=0: filtered value = synchronised sample, combinational.
- Latency: a clean level change sampled at edge 1 updates position at edge FILT_LEN+3.
- Decode: compare the registered previous filtered AB with the current filtered AB.
  - Forward sequence is 00→10→11→01→00; each such step is +1 and sets dir=1.
  - The reverse sequence is −1 and sets dir=0.
  - No change: no action.
  - Both bits changing: illegal. err_cnt increments, saturating at 255. Position, dir and previous state are unaffected except that previous AB takes the new value.
- Position arithmetic: modulo 2^POS_W; 0x7FFF_FFFF+1 → 0x8000_0000 and 0−1 → all ones.
- Position update priority, per cycle: pos_clr > pos_load > (index clear, if IDX_RESET=1) > step. A step coinciding with a higher-priority action is discarded.
- Index capture: on a filtered Z rising edge with index_arm=1:
  - index_pos takes the pre-update value of position in that cycle.
  - index_flag is set.
  - Z edges with index_arm=0 are ignored.
- index_flag clearing: index_ack clears the flag. If ack and a capture occur in the same cycle, the capture wins and the flag stays 1.

Optional Feature:
- Macro: QEI_VELOCITY_EN.
- When defined:
  - A signed VEL_W step accumulator (±1 per valid step) saturates at ±(2^(VEL_W−1)−1); it ignores clr/load/index clear.
  - On vel_strobe, velocity takes the accumulator plus that cycle's step, the accumulator restarts at 0, and vel_valid pulses the next cycle.
- When undefined: velocity and vel_valid are tied 0 and no accumulator logic is generated.

Decomposition:
- Package qei_pkg:
  - step-type encoding (STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR).
  - Forward-sequence constants.
  - ERR_CNT_W=8.
- Sub-module qei_input_filter: one synchroniser plus stability filter, parameterised by FILT_LEN, instantiated three times.

Test Plan:
- Forward sweep, FILT_LEN=4, AB cycling 00,10,11,01,00 ×25 with each level held 8 clks → position=100, dir=1, err_cnt=0; first step appears exactly 7 clks after the first change.
- Reverse 3 steps from 0 → position=0xFFFF_FFFD and dir=0; then pos_load 0x7FFF_FFFF plus one forward step → 0x8000_0000.
- Glitch rejection: 3-clk pulse on A with FILT_LEN=4 → position unchanged, err_cnt=0; AB 00→11 held 8 clks → err_cnt=1, position unchanged.
- Index: arm, position=42, Z rising → index_pos=42, index_flag=1; ack coincident with a second edge at 50 → flag stays 1, index_pos=50. Repeat with IDX_RESET=1 → position=0 after the edge.
- Priority: pos_clr and pos_load asserted with a forward step in the same cycle → position=0; async reset asserted mid-sweep → all outputs 0 immediately.
- QEI_VELOCITY_EN: 10 forward steps, then vel_strobe → velocity=10 and vel_valid high for 1 clk; then 3 reverse steps, then strobe → velocity=−3.
